// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 compression datapath.
package sha256_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef logic [31:0]      word_t;
    typedef logic [0:7][31:0] hash_t;  // index 0 (H0 / a) sits in the MSBs

    typedef enum logic [1:0] {
        s_IDLE   = 2'b00,
        s_ROUND  = 2'b01,
        s_UPDATE = 2'b10,
        s_DONE   = 2'b11
    } fsm_state_e;

    localparam hash_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the 64 SHA-256 round constants K[t].
module sha256_k_rom (
    input  logic [5:0]  idx,
    output logic [31:0] k
);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    assign k = K_TAB[idx];

endmodule

// File: rtl/sha256_round_core.sv
// One-round-per-cycle SHA-256 compression core; W[t] is streamed in by an
// external message expander and the running hash H is kept for chaining.
module sha256_round_core
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_in,
    input  logic                      start_in,
    input  logic                      w_valid_in,
    input  logic [DATA_WIDTH-1:0]     w_in,
    output logic                      ready_out,
    output logic [8*DATA_WIDTH-1:0]   digest_out,
    output logic                      digest_dv_out,
    output logic [1:0]                o_FSM_state,
    output logic [5:0]                o_round
);

    fsm_state_e state_q, state_d;
    logic [5:0] round_q, round_d;
    hash_t      wv_q, wv_d;
    hash_t      h_q, h_d;

    word_t k_t;
    word_t a, b, c, d, e, f, g, h;
    word_t sum0, sum1, ch, maj, t1, t2;

    sha256_k_rom u_k_rom (
        .idx (round_q),
        .k   (k_t)
    );

    assign {a, b, c, d, e, f, g, h} = wv_q;

    assign sum0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    assign sum1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    assign ch   = (e & f) ^ (~e & g);
    assign maj  = (a & b) ^ (a & c) ^ (b & c);
    assign t1   = h + sum1 + ch + k_t + w_in;
    assign t2   = sum0 + maj;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wv_d    = wv_q;
        h_d     = h_q;
        unique case (state_q)
            s_IDLE: begin
                if (start_in) begin
                    if (init_in) begin
                        h_d  = SHA256_IV;
                        wv_d = SHA256_IV;
                    end else begin
                        wv_d = h_q;
                    end
                    round_d = '0;
                    state_d = s_ROUND;
                end
            end
            s_ROUND: begin
                if (w_valid_in) begin
                    wv_d    = {t1 + t2, a, b, c, d + t1, e, f, g};
                    round_d = round_q + 6'd1;  // wraps to 0 after round 63
                    if (round_q == 6'd63) begin
                        state_d = s_UPDATE;
                    end
                end
            end
            s_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                end
                state_d = s_DONE;
            end
            s_DONE: begin
                state_d = s_IDLE;
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= s_IDLE;
            round_q <= '0;
            wv_q    <= '0;
            h_q     <= SHA256_IV;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wv_q    <= wv_d;
            h_q     <= h_d;
        end
    end

    assign ready_out     = (state_q == s_IDLE);
    assign digest_dv_out = (state_q == s_DONE);
    assign o_FSM_state   = state_q;
    assign o_round       = round_q;
    assign digest_out    = h_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// Directed bench: known-answer digests, stalls, ignored start and mid-block reset.
module tb_sha256_round_core;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_in = 1'b0;
    logic         start_in = 1'b0;
    logic         w_valid_in = 1'b0;
    logic [31:0]  w_in = '0;
    logic         ready_out;
    logic [255:0] digest_out;
    logic         digest_dv_out;
    logic [1:0]   o_FSM_state;
    logic [5:0]   o_round;

    int n_total = 0;
    int n_bad = 0;
    int dv_count = 0;
    logic [31:0] w_sched [64];

    sha256_round_core #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_in       (init_in),
        .start_in      (start_in),
        .w_valid_in    (w_valid_in),
        .w_in          (w_in),
        .ready_out     (ready_out),
        .digest_out    (digest_out),
        .digest_dv_out (digest_dv_out),
        .o_FSM_state   (o_FSM_state),
        .o_round       (o_round)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (digest_dv_out === 1'b1) dv_count <= dv_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule reference model: fills W[16..63] from W[0..15].
    task automatic expand();
        logic [31:0] s0, s1;
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3);
            s1 = rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10);
            w_sched[t] = w_sched[t-16] + s0 + w_sched[t-7] + s1;
        end
    endtask

    task automatic load_msg(input int which);
        for (int i = 0; i < 64; i++) w_sched[i] = '0;
        case (which)
            0: begin w_sched[0] = 32'h61626380; w_sched[15] = 32'h00000018; end
            1: w_sched[0] = 32'h80000000;
            2: begin
                w_sched[0]  = 32'h61626364; w_sched[1]  = 32'h62636465;
                w_sched[2]  = 32'h63646566; w_sched[3]  = 32'h64656667;
                w_sched[4]  = 32'h65666768; w_sched[5]  = 32'h66676869;
                w_sched[6]  = 32'h6768696a; w_sched[7]  = 32'h68696a6b;
                w_sched[8]  = 32'h696a6b6c; w_sched[9]  = 32'h6a6b6c6d;
                w_sched[10] = 32'h6b6c6d6e; w_sched[11] = 32'h6c6d6e6f;
                w_sched[12] = 32'h6d6e6f70; w_sched[13] = 32'h6e6f7071;
                w_sched[14] = 32'h80000000;
            end
            default: w_sched[15] = 32'h000001c0;
        endcase
        expand();
    endtask

    // Runs one block from s_IDLE; called and returns on a negedge.
    task automatic do_block(input logic init, input int max_gap, input int start_at,
                            input int abort_at, input logic chk_dig, input logic [255:0] exp);
        int dv0;
        int gap;
        logic [255:0] h_before;
        dv0 = dv_count;
        h_before = digest_out;
        chk("ready_idle", ready_out, 1);
        start_in = 1'b1; init_in = init; w_valid_in = 1'b1; w_in = $urandom;
        @(negedge clk);
        start_in = 1'b0; init_in = 1'b0; w_valid_in = 1'b0;
        chk("start_state", o_FSM_state, 2'b01);
        chk("start_round", o_round, 0);
        chk("start_ready", ready_out, 0);
        chk("start_h", digest_out, init ? IV : h_before);
        for (int t = 0; t < 64; t++) begin
            if (t == abort_at) begin
                chk("pre_abort_round", o_round, t);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_state", o_FSM_state, 2'b00);
                chk("abort_round", o_round, 0);
                chk("abort_digest", digest_out, IV);
                chk("abort_dv", digest_dv_out, 0);
                chk("abort_ready", ready_out, 1);
                @(negedge clk);
                chk("abort_no_pulse", dv_count, dv0);
                return;
            end
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                w_valid_in = 1'b0; w_in = $urandom;
                @(negedge clk);
                chk("stall_round", o_round, t);
            end
            chk("round_idx", o_round, t);
            start_in = (t == start_at); init_in = (t == start_at);
            w_valid_in = 1'b1; w_in = w_sched[t];
            @(negedge clk);
            start_in = 1'b0; init_in = 1'b0;
        end
        // W[63] just accepted; junk on w_valid/start must be ignored in s_UPDATE.
        w_valid_in = 1'b1; w_in = $urandom; start_in = 1'b1;
        chk("upd_state", o_FSM_state, 2'b10);
        chk("upd_round", o_round, 0);
        chk("upd_dv", digest_dv_out, 0);
        @(negedge clk);
        start_in = 1'b0;
        chk("done_state", o_FSM_state, 2'b11);
        chk("done_dv", digest_dv_out, 1);
        if (chk_dig) chk("digest", digest_out, exp);
        @(negedge clk);
        w_valid_in = 1'b0;
        chk("post_dv", digest_dv_out, 0);
        chk("post_state", o_FSM_state, 2'b00);
        chk("dv_pulses", dv_count - dv0, 1);
        if (chk_dig) chk("digest_hold", digest_out, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", o_FSM_state, 2'b00);
        chk("rst_round", o_round, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_dv", digest_dv_out, 0);
        chk("rst_digest", digest_out, IV);

        // Idle with w_valid high: nothing may move.
        w_valid_in = 1'b1; w_in = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        w_valid_in = 1'b0;
        chk("idle_state", o_FSM_state, 2'b00);
        chk("idle_round", o_round, 0);
        chk("idle_digest", digest_out, IV);

        load_msg(0); do_block(1'b1, 0, -1, -1, 1'b1, DIG_ABC);
        load_msg(1); do_block(1'b1, 0, -1, -1, 1'b1, DIG_EMPTY);

        begin
            int dv_start;
            dv_start = dv_count;
            load_msg(2); do_block(1'b1, 0, -1, -1, 1'b0, '0);
            load_msg(3); do_block(1'b0, 0, -1, -1, 1'b1, DIG_TWO);
            chk("two_block_pulses", dv_count - dv_start, 2);
        end

        load_msg(0); do_block(1'b1, 5, -1, -1, 1'b1, DIG_ABC);

        // Leave H at a non-IV value so the reset restoring H is observable.
        load_msg(1); do_block(1'b1, 0, -1, -1, 1'b1, DIG_EMPTY);
        load_msg(0); do_block(1'b0, 2, 20, 30, 1'b0, '0);
        // Chaining from H after reset must equal a fresh IV start.
        load_msg(0); do_block(1'b0, 0, -1, -1, 1'b1, DIG_ABC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_round_core.md
SHA256_ROUND_CORE -- requirements
Module: sha256_round_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the word width (only 32 is supported).
REQ-002 SHALL have port clk, input, 1 bit: the single clock. One clock; reset is synchronous and active-high.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port init_in, input, 1 bit: when high together with start_in, H is reloaded from the IV (first block of a message).
REQ-005 SHALL have port start_in, input, 1 bit: begin compressing one 512-bit block; sampled in s_IDLE only.
REQ-006 SHALL have port w_valid_in, input, 1 bit: w_in carries W[t] for the current round.
REQ-007 SHALL have port w_in, input, DATA_WIDTH bits: schedule word W[t], supplied by the upstream message expander in order t = 0..63.
REQ-008 SHALL have port ready_out, output, 1 bit: high in s_IDLE.
REQ-009 SHALL have port digest_out, output, 8*DATA_WIDTH bits: {H0,...,H7}, with H0 in the MSBs.
REQ-010 SHALL have port digest_dv_out, output, 1 bit: single-cycle pulse when digest_out is updated.
REQ-011 SHALL have port o_FSM_state, output, 2 bits: current state encoding.
REQ-012 SHALL have port o_round, output, 6 bits: index of the next round to execute.

Function
REQ-013 SHALL use states s_IDLE=00, s_ROUND=01, s_UPDATE=10, s_DONE=11.
REQ-014 s_IDLE, start_in=1: load working registers a..h from H (from the IV if init_in=1, and H itself is also set to the IV); round=0; go to s_ROUND.
REQ-015 s_IDLE, start_in=0: hold state; w_valid_in is ignored.
REQ-016 s_ROUND, w_valid_in=1: execute one round t=o_round using K[t] and w_in, then increment the round counter.
REQ-017 s_ROUND, w_valid_in=0: stall; a..h and the round counter hold.
REQ-018 Round arithmetic: T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = Σ0(a) + Maj(a,b,c); all additions mod 2^32.
REQ-019 Round state update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
REQ-020 Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
REQ-021 When round 63 is accepted, go to s_UPDATE; the round counter wraps to 0.
REQ-022 s_UPDATE: H0..H7 <= H0..H7 + a..h (mod 2^32 per word); go to s_DONE.
REQ-023 s_DONE: digest_dv_out=1 (decoded from state) for exactly one cycle; go to s_IDLE.
REQ-024 Latency: digest_dv_out SHALL be high in the 2nd cycle after the clock edge that accepts W[63].
REQ-025 start_in outside s_IDLE SHALL be ignored and have no effect on the block in flight.
REQ-026 w_valid_in outside s_ROUND SHALL be ignored; no W word is consumed.
REQ-027 A block started with init_in=0 SHALL chain from the previous digest in H (multi-block messages).
REQ-028 digest_out SHALL always reflect the H registers and stay stable between updates.

Reset
REQ-029 rst=1 at a clock edge SHALL force s_IDLE, round=0, a..h=0, H=IV, and digest_dv_out=0; ready_out is 1 from the next cycle.
REQ-030 A reset at any point mid-block SHALL abort the block with no digest pulse; the next start_in SHALL behave as if after power-up.

Structure
REQ-031 Shared package sha256_pkg SHALL hold the IV constants (6a09e667...5be0cd19), the state encodings, and DATA_WIDTH default.
REQ-032 Sub-module sha256_k_rom SHALL be a combinational 64-entry lookup with a 6-bit index in and a 32-bit K[t] out.
REQ-033 Σ0, Σ1, Ch and Maj SHALL be implemented inline.

Verification
REQ-034 Scenario "abc": init_in=1+start_in; feed W0=61626380, W1..W14=0, W15=00000018, and W16..63 from the model -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, one dv pulse.
REQ-035 Scenario empty message: W0=80000000, all other words 0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-036 Scenario two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with init_in=1, block 2 with init_in=0 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; exactly 2 dv pulses.
REQ-037 Scenario stall: "abc" with random w_valid_in gaps (up to 5 cycles) -> the same digest; o_round holds during each gap; dv arrives 2 cycles after W63 is accepted.
REQ-038 Scenario abort/ignore: start_in pulsed at round 20 -> ignored; rst asserted at round 30 -> state 00, digest_out=IV, no dv pulse; a following "abc" run gives the correct digest.
